// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL PI loop filter: widths, defaults,
// common types and the tuning-word clamp.
package adpll_pkg;

    localparam int ERR_W       = 16;   // phase-error width, signed
    localparam int CTRL_W      = 12;   // tuning word width, unsigned
    localparam int INT_W       = 24;   // integrator width, signed
    localparam int SUM_W       = INT_W + 2;
    localparam int BIAS        = 154;  // free-running DCO tuning word
    localparam int LOCK_THRESH = 4;    // |err| <= this is in-lock
    localparam int LOCK_COUNT  = 16;   // consecutive in-lock samples for lock

    typedef logic signed [ERR_W-1:0] err_t;
    typedef logic        [CTRL_W-1:0] ctrl_t;
    typedef logic signed [INT_W-1:0] integ_t;
    typedef logic signed [SUM_W-1:0] sum_t;

    // Clamp result: the tuning word plus which rail (if any) was hit.
    typedef struct packed {
        ctrl_t value;
        logic  hi;
        logic  lo;
    } sat_res_t;

    localparam ctrl_t  BIAS_CTRL = ctrl_t'(BIAS);
    localparam integ_t INTEG_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam integ_t INTEG_MIN = {1'b1, {(INT_W-1){1'b0}}};
    localparam sum_t   SUM_ZERO  = sum_t'(0);
    localparam sum_t   SUM_MAX   = sum_t'((1 << CTRL_W) - 1);

    // Clamp a wide signed sum into the unsigned tuning-word range.
    function automatic sat_res_t sat_ctrl(input sum_t sum);
        sat_res_t r;
        r.value = sum[CTRL_W-1:0];
        r.hi    = 1'b0;
        r.lo    = 1'b0;
        if (sum < SUM_ZERO) begin
            r.value = '0;
            r.lo    = 1'b1;
        end else if (sum > SUM_MAX) begin
            r.value = '1;
            r.hi    = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// Lock detector for the ADPLL loop filter: counts consecutive small
// phase errors with a hysteresis band between THRESH and 2*THRESH.
// Only instantiated when LOOP_LOCK_DETECT_EN is defined.
module adpll_lock_detect
    import adpll_pkg::*;
#(
    parameter int THRESH = LOCK_THRESH,
    parameter int COUNT  = LOCK_COUNT
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic             sample_valid_i,
    input  logic [ERR_W-1:0] err_i,
    output logic             lock_o
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] COUNT_C  = CNT_W'(COUNT);
    localparam logic [ERR_W:0]   IN_LIM   = (ERR_W+1)'(THRESH);
    localparam logic [ERR_W:0]   OUT_LIM  = (ERR_W+1)'(2 * THRESH);

    logic [ERR_W:0]   mag;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Magnitude one bit wider so the most negative error maps to 2^(ERR_W-1)
    // and falls naturally into the out-of-lock band.
    always_comb begin
        if (err_i[ERR_W-1]) begin
            mag = {1'b0, ~err_i} + (ERR_W+1)'(1);
        end else begin
            mag = {1'b0, err_i};
        end
    end

    // Counter next state: count up when in-lock, clear when far out, hold between.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (sample_valid_i) begin
            if (mag <= IN_LIM) begin
                if (cnt_q != COUNT_C) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (mag > OUT_LIM) begin
                cnt_d = '0;
            end
        end
    end

    // Counter register; updates on the same edge as the tuning word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign lock_o = (cnt_q == COUNT_C);

endmodule

// File: rtl/adpll_loop_filter.sv
// ADPLL digital PI loop filter. Two-stage pipeline:
//   S1 registers the error, the proportional term and the saturated
//   integrator candidate; S2 adds BIAS, clamps and registers the tuning word.
// Valid/ready: err_valid_i is a one-cycle strobe with no back-pressure; every
// strobe seen while enable_i=1 is accepted and yields exactly one ctrl_valid_o
// pulse two cycles later.
// Optional feature macro: LOOP_LOCK_DETECT_EN (lock detector; lock_o tied 0
// when undefined).
module adpll_loop_filter
    import adpll_pkg::*;
(
    input  logic              clk100_i,
    input  logic              rst_pbn_i,
    input  logic              enable_i,
    input  logic [3:0]        kp_shift_i,
    input  logic [3:0]        ki_shift_i,
    input  logic              err_valid_i,
    input  logic [ERR_W-1:0]  err_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              ctrl_valid_o,
    output logic              sat_o,
    output logic              lock_o
);

    logic accept;

    // S1 pipeline registers
    logic       s1_valid_q, s1_valid_d;
    err_t       s1_err_q,   s1_err_d;
    err_t       s1_p_q,     s1_p_d;
    integ_t     s1_integ_q, s1_integ_d;
    logic [3:0] s1_ki_q,    s1_ki_d;

    // Committed integrator
    integ_t integ_q, integ_d;

    // Output registers
    ctrl_t ctrl_q,  ctrl_d;
    logic  valid_q, valid_d;
    logic  sat_q,   sat_d;

    // Combinational intermediates
    err_t                  err_s;
    err_t                  p_next;
    integ_t                integ_cur;
    logic signed [INT_W:0] integ_sum;
    integ_t                integ_next;
    sum_t                  sum_s2;
    sat_res_t              sat_s2;
    logic                  commit_s2;

    assign accept = enable_i & err_valid_i;

    // S2: form BIAS + P + I, clamp, and decide whether the integrator commits.
    always_comb begin
        sum_s2    = sum_t'(BIAS) + sum_t'(s1_p_q) + sum_t'(s1_integ_q >>> s1_ki_q);
        sat_s2    = sat_ctrl(sum_s2);
        commit_s2 = s1_valid_q &&
                    !((sat_s2.hi && !s1_err_q[ERR_W-1] && (s1_err_q != '0)) ||
                      (sat_s2.lo &&  s1_err_q[ERR_W-1]));
    end

    // S1 combinational: P term and saturating integrator update. The sample in
    // S2 commits on this same edge, so its result is forwarded here to keep
    // back-to-back samples accumulating correctly.
    always_comb begin
        err_s     = $signed(err_i);
        p_next    = err_s >>> kp_shift_i;
        integ_cur = commit_s2 ? s1_integ_q : integ_q;
        integ_sum = {integ_cur[INT_W-1], integ_cur} +
                    {{(INT_W+1-ERR_W){err_s[ERR_W-1]}}, err_s};
        if (integ_sum[INT_W] != integ_sum[INT_W-1]) begin
            integ_next = integ_sum[INT_W] ? INTEG_MIN : INTEG_MAX;
        end else begin
            integ_next = integ_sum[INT_W-1:0];
        end
    end

    // S1 next state: capture the sample and its shift select when accepted.
    always_comb begin
        s1_valid_d = accept;
        s1_err_d   = s1_err_q;
        s1_p_d     = s1_p_q;
        s1_integ_d = s1_integ_q;
        s1_ki_d    = s1_ki_q;
        if (accept) begin
            s1_err_d   = err_s;
            s1_p_d     = p_next;
            s1_integ_d = integ_next;
            s1_ki_d    = ki_shift_i;
        end
    end

    // S1 registers.
    always_ff @(posedge clk100_i or negedge rst_pbn_i) begin
        if (!rst_pbn_i) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= '0;
            s1_p_q     <= '0;
            s1_integ_q <= '0;
            s1_ki_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s1_p_q     <= s1_p_d;
            s1_integ_q <= s1_integ_d;
            s1_ki_q    <= s1_ki_d;
        end
    end

    // Integrator next state: cleared while the loop is open, else committed value.
    always_comb begin
        integ_d = enable_i ? integ_cur : '0;
    end

    // Integrator register.
    always_ff @(posedge clk100_i or negedge rst_pbn_i) begin
        if (!rst_pbn_i) begin
            integ_q <= '0;
        end else begin
            integ_q <= integ_d;
        end
    end

    // Output next state: publish S2 result, or fall back to BIAS once the
    // pipeline is empty with the loop open.
    always_comb begin
        ctrl_d  = ctrl_q;
        sat_d   = sat_q;
        valid_d = 1'b0;
        if (s1_valid_q) begin
            ctrl_d  = sat_s2.value;
            sat_d   = sat_s2.hi | sat_s2.lo;
            valid_d = 1'b1;
        end else if (!enable_i) begin
            ctrl_d = BIAS_CTRL;
            sat_d  = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk100_i or negedge rst_pbn_i) begin
        if (!rst_pbn_i) begin
            ctrl_q  <= BIAS_CTRL;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
        end
    end

    assign ctrl_o       = ctrl_q;
    assign ctrl_valid_o = valid_q;
    assign sat_o        = sat_q;

`ifdef LOOP_LOCK_DETECT_EN
    logic lock_clear;

    // Clear the lock counter only once in-flight samples have drained.
    assign lock_clear = !enable_i && !s1_valid_q;

    adpll_lock_detect #(
        .THRESH (LOCK_THRESH),
        .COUNT  (LOCK_COUNT)
    ) u_lock_detect (
        .clk_i          (clk100_i),
        .rst_n_i        (rst_pbn_i),
        .clear_i        (lock_clear),
        .sample_valid_i (s1_valid_q),
        .err_i          (s1_err_q),
        .lock_o         (lock_o)
    );
`else
    assign lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_adpll_loop_filter.sv
// Directed self-checking bench for adpll_loop_filter.
// Lock expectations follow LOOP_LOCK_DETECT_EN (lock_o stays 0 when undefined).
module tb_adpll_loop_filter;

`ifdef LOOP_LOCK_DETECT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk100_i    = 1'b0;
    logic        rst_pbn_i   = 1'b0;
    logic        enable_i    = 1'b0;
    logic [3:0]  kp_shift_i  = 4'd0;
    logic [3:0]  ki_shift_i  = 4'd0;
    logic        err_valid_i = 1'b0;
    logic [15:0] err_i       = 16'd0;
    logic [11:0] ctrl_o;
    logic        ctrl_valid_o;
    logic        sat_o;
    logic        lock_o;

    int n_cmp = 0;
    int n_bad = 0;

    adpll_loop_filter dut (
        .clk100_i     (clk100_i),
        .rst_pbn_i    (rst_pbn_i),
        .enable_i     (enable_i),
        .kp_shift_i   (kp_shift_i),
        .ki_shift_i   (ki_shift_i),
        .err_valid_i  (err_valid_i),
        .err_i        (err_i),
        .ctrl_o       (ctrl_o),
        .ctrl_valid_o (ctrl_valid_o),
        .sat_o        (sat_o),
        .lock_o       (lock_o)
    );

    // 100 MHz clock
    always #5 clk100_i = ~clk100_i;

    task automatic tick();
        @(posedge clk100_i);
        #1;
    endtask

    // Open the loop long enough to clear integrator and lock state, then close it.
    task automatic clear_loop();
        err_valid_i = 1'b0;
        enable_i    = 1'b0;
        repeat (3) tick();
        enable_i = 1'b1;
    endtask

    // One-cycle strobe; returns just after the accepting edge.
    task automatic send(input logic [15:0] e);
        err_valid_i = 1'b1;
        err_i       = e;
        tick();
        err_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_pbn_i = 1'b0;
        enable_i  = 1'b0;
        #100;
        rst_pbn_i = 1'b1;
        tick();
        n_cmp++; if (ctrl_o !== 12'd154) begin n_bad++; $display("FAIL reset_ctrl: got %0d expected 154", ctrl_o); end
        n_cmp++; if (ctrl_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", ctrl_valid_o); end
        n_cmp++; if (sat_o !== 1'b0) begin n_bad++; $display("FAIL reset_sat: got %b expected 0", sat_o); end
        n_cmp++; if (lock_o !== 1'b0) begin n_bad++; $display("FAIL reset_lock: got %b expected 0", lock_o); end
    endtask

    task automatic test_pi();
        clear_loop();
        kp_shift_i = 4'd2;
        ki_shift_i = 4'd4;
        send(16'd64);
        tick();
        n_cmp++; if (ctrl_valid_o !== 1'b1) begin n_bad++; $display("FAIL pi_valid: got %b expected 1", ctrl_valid_o); end
        n_cmp++; if (ctrl_o !== 12'd174) begin n_bad++; $display("FAIL pi_ctrl1: got %0d expected 174", ctrl_o); end
        tick();
        n_cmp++; if (ctrl_valid_o !== 1'b0) begin n_bad++; $display("FAIL pi_pulse_width: got %b expected 0", ctrl_valid_o); end
        n_cmp++; if (ctrl_o !== 12'd174) begin n_bad++; $display("FAIL pi_gap_hold: got %0d expected 174", ctrl_o); end
        send(16'd0);
        tick();
        n_cmp++; if (ctrl_o !== 12'd158) begin n_bad++; $display("FAIL pi_ctrl2: got %0d expected 158", ctrl_o); end
        n_cmp++; if (sat_o !== 1'b0) begin n_bad++; $display("FAIL pi_sat: got %b expected 0", sat_o); end
    endtask

    task automatic test_saturation();
        logic [15:0] e1 [4] = '{16'd3941, 16'd3942, 16'hFF66, 16'hFF65};  // 3941, 3942, -154, -155
        logic [11:0] c1 [4] = '{12'd4095, 12'd4095, 12'd0, 12'd0};
        logic        s1 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] e2 [5] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000};
        logic [11:0] c2 [5] = '{12'd4095, 12'd4095, 12'd4095, 12'd0, 12'd154};
        logic        s2 [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        // Clamp boundaries with the integral term shifted out of view.
        clear_loop();
        kp_shift_i = 4'd0;
        ki_shift_i = 4'd15;
        for (int i = 0; i < 4; i++) begin
            send(e1[i]);
            tick();
            n_cmp++; if (ctrl_o !== c1[i]) begin n_bad++; $display("FAIL sat_edge_ctrl[%0d]: got %0d expected %0d", i, ctrl_o, c1[i]); end
            n_cmp++; if (sat_o !== s1[i]) begin n_bad++; $display("FAIL sat_edge_flag[%0d]: got %b expected %b", i, sat_o, s1[i]); end
        end
        // Full-scale errors: anti-windup keeps the integrator from charging.
        clear_loop();
        kp_shift_i = 4'd0;
        ki_shift_i = 4'd0;
        for (int i = 0; i < 5; i++) begin
            send(e2[i]);
            tick();
            n_cmp++; if (ctrl_o !== c2[i]) begin n_bad++; $display("FAIL windup_ctrl[%0d]: got %0d expected %0d", i, ctrl_o, c2[i]); end
            n_cmp++; if (sat_o !== s2[i]) begin n_bad++; $display("FAIL windup_sat[%0d]: got %b expected %b", i, sat_o, s2[i]); end
        end
    endtask

    task automatic test_integ_limit();
        // 260 x 32767 drives the integrator to +2^23-1; >>>15 gives 255 -> 154+255.
        clear_loop();
        kp_shift_i  = 4'd15;
        ki_shift_i  = 4'd15;
        err_valid_i = 1'b1;
        err_i       = 16'h7FFF;
        repeat (260) tick();
        err_valid_i = 1'b0;
        tick();
        tick();
        n_cmp++; if (ctrl_o !== 12'd409) begin n_bad++; $display("FAIL integ_limit_ctrl: got %0d expected 409", ctrl_o); end
        n_cmp++; if (sat_o !== 1'b0) begin n_bad++; $display("FAIL integ_limit_sat: got %b expected 0", sat_o); end
        tick();
        n_cmp++; if (ctrl_valid_o !== 1'b0) begin n_bad++; $display("FAIL integ_limit_idle_valid: got %b expected 0", ctrl_valid_o); end
        n_cmp++; if (ctrl_o !== 12'd409) begin n_bad++; $display("FAIL integ_limit_hold: got %0d expected 409", ctrl_o); end
    endtask

    task automatic test_lock();
        logic exp_l;
        clear_loop();
        kp_shift_i = 4'd15;
        ki_shift_i = 4'd15;
        for (int i = 0; i < 16; i++) begin
            send(16'd2);
            tick();
            exp_l = LOCK_EN && (i == 15);
            n_cmp++; if (lock_o !== exp_l) begin n_bad++; $display("FAIL lock_rise[%0d]: got %b expected %b", i, lock_o, exp_l); end
        end
        send(16'd6);
        tick();
        n_cmp++; if (lock_o !== LOCK_EN) begin n_bad++; $display("FAIL lock_hyst_hold: got %b expected %b", lock_o, LOCK_EN); end
        send(16'd9);
        tick();
        n_cmp++; if (lock_o !== 1'b0) begin n_bad++; $display("FAIL lock_drop: got %b expected 0", lock_o); end
        send(16'd2);
        tick();
        n_cmp++; if (lock_o !== 1'b0) begin n_bad++; $display("FAIL lock_restart: got %b expected 0", lock_o); end
        for (int i = 0; i < 15; i++) begin
            send(16'hFFFC);  // -4, in-lock
            tick();
        end
        n_cmp++; if (lock_o !== LOCK_EN) begin n_bad++; $display("FAIL lock_neg_relock: got %b expected %b", lock_o, LOCK_EN); end
        send(16'h8000);
        tick();
        n_cmp++; if (lock_o !== 1'b0) begin n_bad++; $display("FAIL lock_most_negative: got %b expected 0", lock_o); end
    endtask

    task automatic test_disable();
        clear_loop();
        kp_shift_i = 4'd15;
        ki_shift_i = 4'd0;
        send(16'd200);
        tick();
        n_cmp++; if (ctrl_o !== 12'd354) begin n_bad++; $display("FAIL dis_charge: got %0d expected 354", ctrl_o); end
        // One sample in flight when the loop opens; it must still drain.
        err_valid_i = 1'b1;
        err_i       = 16'd0;
        tick();
        err_valid_i = 1'b0;
        enable_i    = 1'b0;
        tick();
        n_cmp++; if (ctrl_valid_o !== 1'b1) begin n_bad++; $display("FAIL dis_drain_valid: got %b expected 1", ctrl_valid_o); end
        n_cmp++; if (ctrl_o !== 12'd354) begin n_bad++; $display("FAIL dis_drain_ctrl: got %0d expected 354", ctrl_o); end
        tick();
        n_cmp++; if (ctrl_valid_o !== 1'b0) begin n_bad++; $display("FAIL dis_bias_valid: got %b expected 0", ctrl_valid_o); end
        n_cmp++; if (ctrl_o !== 12'd154) begin n_bad++; $display("FAIL dis_bias_ctrl: got %0d expected 154", ctrl_o); end
        n_cmp++; if (sat_o !== 1'b0) begin n_bad++; $display("FAIL dis_bias_sat: got %b expected 0", sat_o); end
        n_cmp++; if (lock_o !== 1'b0) begin n_bad++; $display("FAIL dis_bias_lock: got %b expected 0", lock_o); end
        // Strobes while open are ignored.
        err_valid_i = 1'b1;
        err_i       = 16'd500;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (ctrl_valid_o !== 1'b0) begin n_bad++; $display("FAIL dis_ignore_valid[%0d]: got %b expected 0", i, ctrl_valid_o); end
        end
        err_valid_i = 1'b0;
        n_cmp++; if (ctrl_o !== 12'd154) begin n_bad++; $display("FAIL dis_ignore_ctrl: got %0d expected 154", ctrl_o); end
        enable_i = 1'b1;
        send(16'd0);
        tick();
        n_cmp++; if (ctrl_o !== 12'd154) begin n_bad++; $display("FAIL dis_reenable: got %0d expected 154", ctrl_o); end
        n_cmp++; if (ctrl_valid_o !== 1'b1) begin n_bad++; $display("FAIL dis_reenable_valid: got %b expected 1", ctrl_valid_o); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e  [5] = '{16'd16, 16'hFFF0, 16'd16, 16'd64, 16'd64};
        logic [3:0]  kp [5] = '{4'd0, 4'd0, 4'd0, 4'd2, 4'd6};
        logic [3:0]  ki [5] = '{4'd8, 4'd8, 4'd8, 4'd15, 4'd15};
        logic [11:0] c  [5] = '{12'd170, 12'd138, 12'd170, 12'd170, 12'd155};
        clear_loop();
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                err_valid_i = 1'b1;
                err_i       = e[i];
                kp_shift_i  = kp[i];
                ki_shift_i  = ki[i];
            end else begin
                err_valid_i = 1'b0;
            end
            tick();
            if (i >= 1) begin
                n_cmp++; if (ctrl_valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i - 1, ctrl_valid_o); end
                n_cmp++; if (ctrl_o !== c[i-1]) begin n_bad++; $display("FAIL b2b_ctrl[%0d]: got %0d expected %0d", i - 1, ctrl_o, c[i-1]); end
            end
        end
        tick();
        n_cmp++; if (ctrl_valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_end_valid: got %b expected 0", ctrl_valid_o); end
    endtask

    task automatic test_reset_mid_stream();
        clear_loop();
        kp_shift_i  = 4'd0;
        ki_shift_i  = 4'd0;
        err_valid_i = 1'b1;
        err_i       = 16'd1000;
        tick();
        tick();
        #2;
        rst_pbn_i = 1'b0;
        #1;
        n_cmp++; if (ctrl_o !== 12'd154) begin n_bad++; $display("FAIL mid_rst_ctrl: got %0d expected 154", ctrl_o); end
        n_cmp++; if (ctrl_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b expected 0", ctrl_valid_o); end
        tick();
        err_valid_i = 1'b0;
        tick();
        rst_pbn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (ctrl_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_rel_valid[%0d]: got %b expected 0", i, ctrl_valid_o); end
            n_cmp++; if (ctrl_o !== 12'd154) begin n_bad++; $display("FAIL mid_rel_ctrl[%0d]: got %0d expected 154", i, ctrl_o); end
        end
        n_cmp++; if (lock_o !== 1'b0) begin n_bad++; $display("FAIL mid_rel_lock: got %b expected 0", lock_o); end
        // Integrator must have been discarded by the reset.
        kp_shift_i = 4'd15;
        ki_shift_i = 4'd0;
        send(16'd0);
        tick();
        n_cmp++; if (ctrl_o !== 12'd154) begin n_bad++; $display("FAIL mid_rel_integ: got %0d expected 154", ctrl_o); end
    endtask

    initial begin
        test_reset();
        test_pi();
        test_saturation();
        test_integ_limit();
        test_lock();
        test_disable();
        test_back_to_back();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
